// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU (quotient->LO, remainder->HI)
// Optional feature macro: DIV_ZERO_TRAP_EN (early completion plus div_zero flag on a zero divisor).
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
`ifdef DIV_ZERO_TRAP_EN
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
`else
    output logic [WIDTH-1:0] remainder
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH-1:0] dvd_abs;
    logic [WIDTH-1:0] dvs_abs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    always_comb begin
        dvd_abs = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
        dvs_abs = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
        // The bit shifted out of rem is kept as the MSB so the trial subtraction never overflows.
        shifted = {rem_q, quo_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        dz_d        = dz_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    state_d = S_RUN;
                    cnt_d   = CW'(WIDTH);
                    rem_d   = '0;
                    quo_d   = dvd_abs;
                    dvs_d   = dvs_abs;
                    q_neg_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    r_neg_d = is_signed && dividend[WIDTH-1];
                    dz_d    = (divisor == '0);
`ifdef DIV_ZERO_TRAP_EN
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                    end
`endif
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    // A zero divisor yields all-ones bits, but the sign fix-up must not touch them.
                    quotient_d  = dz_q ? '1 : (q_neg_q ? -quo_q : quo_q);
                    remainder_d = r_neg_q ? -rem_q : rem_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = S_IDLE;
            quotient_d  = quotient_q;
            remainder_d = remainder_q;
            div_zero_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dz_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            dz_q        <= dz_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_TRAP_EN
    assign div_zero  = div_zero_q;
`else
    logic unused_dz;
    assign unused_dz = div_zero_q;
`endif

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit with directed DIV/DIVU vectors
module tb_div_unit;

    localparam int W = 32;
`ifdef DIV_ZERO_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done;
    logic [W-1:0] quotient, remainder;
    logic         dz_obs;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    div_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
`ifdef DIV_ZERO_TRAP_EN
        .quotient(quotient), .remainder(remainder), .div_zero(dz_obs)
`else
        .quotient(quotient), .remainder(remainder)
`endif
    );
`ifndef DIV_ZERO_TRAP_EN
    assign dz_obs = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", 64'(quotient), 64'(e.q));
                check("remainder", 64'(remainder), 64'(e.r));
                check("div_zero", 64'(dz_obs), 64'(e.dz));
            end
        end
    end

    task automatic run_op(input logic [W-1:0] dvd, input logic [W-1:0] dvs, input logic sgn,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                          input int exp_lat);
        int lat;
        @(negedge clk);
        dividend = dvd; divisor = dvs; is_signed = sgn; start = 1'b1;
        sb.push_back('{q: eq, r: er, dz: edz});
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'(1));
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_in_done", 64'(busy), 64'(1));
        @(posedge clk); #1;
        check("done_one_cycle", 64'(done), 64'(0));
        check("busy_falls", 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_div_zero", 64'(dz_obs), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W + 1);
        run_op(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, W + 1);
        run_op(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0, W + 1);
        run_op(32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3, 32'hFFFFFFFF, 1'b0, W + 1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0, W + 1);
        run_op(32'h80000000, 32'hFFFFFFFF, 1'b0, 32'd0, 32'h80000000, 1'b0, W + 1);
        run_op(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0, W + 1);
        run_op(32'd5, 32'd0, 1'b0, 32'hFFFFFFFF, 32'd5, TRAP, TRAP ? 1 : W + 1);
        run_op(32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFB, TRAP, TRAP ? 1 : W + 1);

        // start held high with changing operands during RUN must not disturb the result
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        sb.push_back('{q: 32'd14, r: 32'd2, dz: 1'b0});
        @(posedge clk); #1;
        dividend = 32'd50; divisor = 32'd3;
        lat = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk); #1;
            if (k == 20) start = 1'b0;
            if (done) begin
                lat = k;
                break;
            end
        end
        check("held_start_latency", 64'(lat), 64'(W + 1));
        repeat (3) @(posedge clk);
        #1;
        check("held_start_idle", 64'(busy), 64'(0));

        // flush at E10 aborts without a done pulse and keeps prior results
        @(negedge clk);
        dividend = 32'd200; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'(0));
        check("flush_done", 64'(done), 64'(0));
        check("flush_keep_q", 64'(quotient), 64'(14));
        check("flush_keep_r", 64'(remainder), 64'(2));
        repeat (40) @(posedge clk);
        #1;
        check("flush_still_idle", 64'(busy), 64'(0));

        // flush and start on the same edge: start dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        check("flush_beats_start", 64'(busy), 64'(0));

        // asynchronous reset in the middle of an operation
        @(negedge clk);
        dividend = 32'd1000; divisor = 32'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 64'(busy), 64'(0));
        check("mid_rst_done", 64'(done), 64'(0));
        check("mid_rst_q", 64'(quotient), 64'(0));
        check("mid_rst_r", 64'(remainder), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, W + 1);
        run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, W + 1);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
